// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the execute-side flag stage.
//   - ALU opcode encodings (ALU_ADD .. ALU_LHB, ALU_LAST = highest legal code)
//   - branch condition codes (CC_NE .. CC_UNCOND)
//   - bit positions of N/Z/V inside the 3-bit flag register
//   - helpers classifying an opcode: legality and which flags it writes
package cpu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_XOR    = 4'd2,
    ALU_RED    = 4'd3,
    ALU_SLL    = 4'd4,
    ALU_SRA    = 4'd5,
    ALU_ROR    = 4'd6,
    ALU_PADDSB = 4'd7,
    ALU_LLB    = 4'd8,
    ALU_LHB    = 4'd9
  } alu_op_t;

  localparam logic [3:0] ALU_LAST = 4'd9;

  typedef enum logic [2:0] {
    CC_NE     = 3'd0,
    CC_EQ     = 3'd1,
    CC_GT     = 3'd2,
    CC_LT     = 3'd3,
    CC_GE     = 3'd4,
    CC_LE     = 3'd5,
    CC_OV     = 3'd6,
    CC_UNCOND = 3'd7
  } cond_t;

  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    FLAG_UPD_NONE = 2'd0,
    FLAG_UPD_NZV  = 2'd1,
    FLAG_UPD_Z    = 2'd2
  } flag_upd_t;

  function automatic logic is_illegal_op(input logic [3:0] op);
    return op > ALU_LAST;
  endfunction

  // Illegal opcodes fall into the default arm, so they never disturb flags.
  function automatic flag_upd_t flag_upd_kind(input logic [3:0] op);
    flag_upd_t kind;
    case (op)
      ALU_ADD, ALU_SUB:                   kind = FLAG_UPD_NZV;
      ALU_XOR, ALU_SLL, ALU_SRA, ALU_ROR: kind = FLAG_UPD_Z;
      default:                            kind = FLAG_UPD_NONE;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/ex_flag_stage_if.sv
// ALU-to-EX/MEM bus of the flag stage.
//   in_*  : instruction leaving the ALU stage (driven by the master)
//   ex_*  : registered EX/MEM pipeline fields (driven by the stage, slave)
// Modports: master = upstream/testbench side, slave = ex_flag_stage.
interface ex_flag_stage_if #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 4
);
  logic               in_valid;
  logic [3:0]         aluop;
  logic [DATA_W-1:0]  aluout;
  logic               alu_err;
  logic [RADDR_W-1:0] in_rd;
  logic               in_reg_we;
  logic               in_mem_rd;
  logic               in_mem_wr;
  logic [DATA_W-1:0]  in_store_data;

  logic               ex_valid;
  logic [DATA_W-1:0]  ex_result;
  logic [RADDR_W-1:0] ex_rd;
  logic               ex_reg_we;
  logic               ex_mem_rd;
  logic               ex_mem_wr;
  logic [DATA_W-1:0]  ex_store_data;

  modport master (
    output in_valid, aluop, aluout, alu_err, in_rd, in_reg_we,
           in_mem_rd, in_mem_wr, in_store_data,
    input  ex_valid, ex_result, ex_rd, ex_reg_we, ex_mem_rd,
           ex_mem_wr, ex_store_data
  );

  modport slave (
    input  in_valid, aluop, aluout, alu_err, in_rd, in_reg_we,
           in_mem_rd, in_mem_wr, in_store_data,
    output ex_valid, ex_result, ex_rd, ex_reg_we, ex_mem_rd,
           ex_mem_wr, ex_store_data
  );
endinterface

// File: rtl/ex_flag_stage_cond_eval.sv
// cond_eval: combinational branch-condition evaluator.
//   cond  [2:0] in  : condition code (cond_t)
//   flags [2:0] in  : {N,Z,V}
//   taken       out : condition holds
module cond_eval
  import cpu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken
);

  logic n, z, v;

  always_comb begin
    n     = flags[FLAG_N];
    z     = flags[FLAG_Z];
    v     = flags[FLAG_V];
    taken = 1'b0;
    case (cond)
      CC_NE:     taken = ~z;
      CC_EQ:     taken = z;
      CC_GT:     taken = ~z & ~n;
      CC_LT:     taken = n;
      CC_GE:     taken = z | ~n;
      CC_LE:     taken = n | z;
      CC_OV:     taken = v;
      CC_UNCOND: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_flag_stage.sv
// ex_flag_stage: execute-side stage downstream of the ALU.
// Captures the ALU result into the EX/MEM register, keeps the {N,Z,V} flag
// register, evaluates decode-stage branch conditions and latches a sticky
// illegal-opcode error that halts retirement until reset.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : in_* from the ALU stage, registered ex_* outputs
//   stall, flush      : hold stage / turn captured slot into a bubble
//   br_valid, br_cond : branch request from decode; br_taken = decision
//   flags             : {N,Z,V}
//   halt_err          : sticky illegal-opcode error
// Build option: EX_FLAG_STAGE_FLAG_FWD_EN -- when defined, br_taken sees the
// flags being written by an instruction captured in the same cycle.
module ex_flag_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ex_flag_stage_if.slave       bus,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 br_valid,
  input  logic [2:0]           br_cond,
  output logic                 br_taken,
  output logic [2:0]           flags,
  output logic                 halt_err
);

  logic               ex_valid_q;
  logic [DATA_W-1:0]  ex_result_q;
  logic [RADDR_W-1:0] ex_rd_q;
  logic               ex_reg_we_q;
  logic               ex_mem_rd_q;
  logic               ex_mem_wr_q;
  logic [DATA_W-1:0]  ex_store_data_q;
  logic [2:0]         flags_q;
  logic               halt_q;

  logic               capture;
  logic               illegal;
  logic               legal_valid;
  logic               res_zero;
  logic [2:0]         flags_nxt;
  logic [2:0]         flags_br;
  logic               cond_taken;

  assign capture     = bus.in_valid & ~stall & ~flush & ~halt_q;
  assign illegal     = is_illegal_op(bus.aluop);
  assign legal_valid = bus.in_valid & ~illegal;
  assign res_zero    = (bus.aluout == '0);

  always_comb begin
    flags_nxt = flags_q;
    if (capture) begin
      case (flag_upd_kind(bus.aluop))
        FLAG_UPD_NZV: begin
          flags_nxt[FLAG_N] = bus.aluout[DATA_W-1];
          flags_nxt[FLAG_Z] = res_zero;
          flags_nxt[FLAG_V] = bus.alu_err;
        end
        FLAG_UPD_Z: flags_nxt[FLAG_Z] = res_zero;
        default:    flags_nxt = flags_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q      <= 1'b0;
      ex_result_q     <= '0;
      ex_rd_q         <= '0;
      ex_reg_we_q     <= 1'b0;
      ex_mem_rd_q     <= 1'b0;
      ex_mem_wr_q     <= 1'b0;
      ex_store_data_q <= '0;
      flags_q         <= 3'b000;
      halt_q          <= 1'b0;
    end else if (halt_q || flush) begin
      // Halted stage and flushed slot both present a zeroed bubble.
      ex_valid_q      <= 1'b0;
      ex_result_q     <= '0;
      ex_rd_q         <= '0;
      ex_reg_we_q     <= 1'b0;
      ex_mem_rd_q     <= 1'b0;
      ex_mem_wr_q     <= 1'b0;
      ex_store_data_q <= '0;
    end else if (!stall) begin
      // Illegal ops still capture their data fields but never retire.
      ex_valid_q      <= legal_valid;
      ex_result_q     <= bus.in_valid ? bus.aluout        : '0;
      ex_rd_q         <= bus.in_valid ? bus.in_rd         : '0;
      ex_store_data_q <= bus.in_valid ? bus.in_store_data : '0;
      ex_reg_we_q     <= legal_valid & bus.in_reg_we;
      ex_mem_rd_q     <= legal_valid & bus.in_mem_rd;
      ex_mem_wr_q     <= legal_valid & bus.in_mem_wr;
      flags_q         <= flags_nxt;
      if (bus.in_valid && illegal) halt_q <= 1'b1;
    end
  end

`ifdef EX_FLAG_STAGE_FLAG_FWD_EN
  assign flags_br = flags_nxt;
`else
  assign flags_br = flags_q;
`endif

  cond_eval u_cond_eval (
    .cond  (br_cond),
    .flags (flags_br),
    .taken (cond_taken)
  );

  assign br_taken = br_valid & cond_taken & ~halt_q & ~rst;

  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_result     = ex_result_q;
  assign bus.ex_rd         = ex_rd_q;
  assign bus.ex_reg_we     = ex_reg_we_q;
  assign bus.ex_mem_rd     = ex_mem_rd_q;
  assign bus.ex_mem_wr     = ex_mem_wr_q;
  assign bus.ex_store_data = ex_store_data_q;
  assign flags             = flags_q;
  assign halt_err          = halt_q;

endmodule

// File: tb/tb_ex_flag_stage.sv
// Directed self-checking bench for ex_flag_stage.
module tb_ex_flag_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall, flush, br_valid;
  logic [2:0] br_cond;
  logic       br_taken;
  logic [2:0] flags;
  logic       halt_err;
  logic       exp_fwd;

  int checks   = 0;
  int failures = 0;

  ex_flag_stage_if #(.DATA_W(16), .RADDR_W(4)) bus ();

  ex_flag_stage #(.DATA_W(16), .RADDR_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .stall    (stall),
    .flush    (flush),
    .br_valid (br_valid),
    .br_cond  (br_cond),
    .br_taken (br_taken),
    .flags    (flags),
    .halt_err (halt_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                       input logic err, input logic [3:0] rd, input logic we,
                       input logic mrd, input logic mwr, input logic [15:0] sd);
    bus.in_valid      = v;
    bus.aluop         = op;
    bus.aluout        = res;
    bus.alu_err       = err;
    bus.in_rd         = rd;
    bus.in_reg_we     = we;
    bus.in_mem_rd     = mrd;
    bus.in_mem_wr     = mwr;
    bus.in_store_data = sd;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic rand_inputs();
    drive(1'($urandom), 4'($urandom), 16'($urandom), 1'($urandom), 4'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
    stall = 1'($urandom);
    flush = 1'($urandom);
  endtask

  task automatic br(input logic [2:0] cc, input logic exp, input string tag);
    br_valid = 1'b1;
    br_cond  = cc;
    #1;
    chk(tag, 32'(br_taken), 32'(exp));
  endtask

  initial begin
`ifdef EX_FLAG_STAGE_FLAG_FWD_EN
    exp_fwd = 1'b1;
`else
    exp_fwd = 1'b0;
`endif
    rst = 1'b1; br_valid = 1'b0; br_cond = 3'd0;
    rand_inputs(); step();
    rand_inputs(); step();
    chk("rst_ex_valid",  32'(bus.ex_valid), 32'h0);
    chk("rst_ex_result", 32'(bus.ex_result), 32'h0);
    chk("rst_ex_rd",     32'(bus.ex_rd), 32'h0);
    chk("rst_ctrl",      32'({bus.ex_reg_we, bus.ex_mem_rd, bus.ex_mem_wr}), 32'h0);
    chk("rst_store",     32'(bus.ex_store_data), 32'h0);
    chk("rst_flags",     32'(flags), 32'h0);
    chk("rst_halt",      32'(halt_err), 32'h0);
    br(3'd7, 1'b0, "rst_br_forced0");

    // ADD with overflow
    rst = 1'b0; stall = 1'b0; flush = 1'b0; br_valid = 1'b0;
    drive(1'b1, 4'd0, 16'h7FFF, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 16'h1234);
    step();
    chk("add_valid",  32'(bus.ex_valid), 32'h1);
    chk("add_result", 32'(bus.ex_result), 32'h7FFF);
    chk("add_rd",     32'(bus.ex_rd), 32'h3);
    chk("add_we",     32'(bus.ex_reg_we), 32'h1);
    chk("add_store",  32'(bus.ex_store_data), 32'h1234);
    chk("add_flags",  32'(flags), 32'b001);
    idle();
    br(3'd6, 1'b1, "br_ov");
    br(3'd0, 1'b1, "br_ne");
    br(3'd1, 1'b0, "br_eq_after_add");
    br(3'd2, 1'b1, "br_gt");
    br_valid = 1'b0;

    // SUB to zero, then XOR (Z only; err must not reach V)
    drive(1'b1, 4'd1, 16'h0000, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 16'h0);
    step();
    chk("sub_flags", 32'(flags), 32'b010);
    drive(1'b1, 4'd2, 16'h8000, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 16'h0);
    step();
    chk("xor_flags", 32'(flags), 32'b000);
    idle();
    br(3'd1, 1'b0, "br_eq_after_xor");
    br_valid = 1'b0;
    step();
    chk("bubble_valid",  32'(bus.ex_valid), 32'h0);
    chk("bubble_we",     32'(bus.ex_reg_we), 32'h0);
    chk("bubble_result", 32'(bus.ex_result), 32'h0);

    // Stall then flush with stall
    drive(1'b1, 4'd0, 16'h0005, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1, 16'hBEEF);
    step();
    chk("pre_stall_result", 32'(bus.ex_result), 32'h5);
    chk("pre_stall_memwr",  32'(bus.ex_mem_wr), 32'h1);
    drive(1'b1, 4'd0, 16'h8000, 1'b1, 4'd6, 1'b1, 1'b1, 1'b0, 16'h0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_result", 32'(bus.ex_result), 32'h5);
      chk("stall_valid",  32'(bus.ex_valid), 32'h1);
      chk("stall_rd",     32'(bus.ex_rd), 32'h5);
      chk("stall_flags",  32'(flags), 32'b000);
    end
    flush = 1'b1;
    step();
    chk("flush_valid", 32'(bus.ex_valid), 32'h0);
    chk("flush_ctrl",  32'({bus.ex_reg_we, bus.ex_mem_rd, bus.ex_mem_wr}), 32'h0);
    chk("flush_flags", 32'(flags), 32'b000);
    stall = 1'b0;
    drive(1'b1, 4'd1, 16'h0000, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 16'h0);
    step();
    chk("flush_only_flags", 32'(flags), 32'b000);
    chk("flush_only_valid", 32'(bus.ex_valid), 32'h0);
    flush = 1'b0;

    // Illegal opcode
    drive(1'b1, 4'hC, 16'h0000, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 16'h0);
    step();
    chk("ill_halt",  32'(halt_err), 32'h1);
    chk("ill_valid", 32'(bus.ex_valid), 32'h0);
    chk("ill_we",    32'(bus.ex_reg_we), 32'h0);
    chk("ill_flags", 32'(flags), 32'b000);
    drive(1'b1, 4'd0, 16'h0000, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 16'h0);
    step();
    chk("halt_add_valid", 32'(bus.ex_valid), 32'h0);
    chk("halt_add_flags", 32'(flags), 32'b000);
    chk("halt_sticky",    32'(halt_err), 32'h1);
    br(3'd7, 1'b0, "halt_br_forced0");
    br_valid = 1'b0;
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_clears_halt", 32'(halt_err), 32'h0);
    br(3'd7, 1'b1, "br_uncond");

    // Forwarding: SUB -> 0 captured alongside an EQ branch
    drive(1'b1, 4'd1, 16'h0000, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 16'h0);
    br(3'd1, exp_fwd, "fwd_eq_same_cycle");
    step();
    idle();
    chk("fwd_flags", 32'(flags), 32'b010);
    br(3'd1, 1'b1, "br_eq_next");
    br(3'd2, 1'b0, "br_gt_z");
    br(3'd4, 1'b1, "br_ge_z");
    br(3'd5, 1'b1, "br_le_z");
    br_valid = 1'b0;
    drive(1'b1, 4'd1, 16'h8000, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 16'h0);
    step();
    idle();
    chk("neg_flags", 32'(flags), 32'b100);
    br(3'd3, 1'b1, "br_lt_n");
    br(3'd4, 1'b0, "br_ge_n");
    br(3'd2, 1'b0, "br_gt_n");
    drive(1'b1, 4'd8, 16'h0000, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 16'h0);
    br(3'd3, 1'b1, "br_lt_llb_cycle");
    step();
    chk("llb_flags", 32'(flags), 32'b100);
    br_valid = 1'b0;
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
